// File: rtl/rv32_machine_csr_file.sv
// Machine-mode CSR file for the RV32 core: CSR read/modify/write, 64-bit cycle and
// instret counters, and trap entry / mret handling that steers the fetch redirect.
module rv32_machine_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iaddr_in,
    input  logic        misaligned_in,
    input  logic        mret_in,
    input  logic        instret_inc_in,
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    output logic [31:0] csr_data_out,
    output logic        trap_taken_out,
    output logic [31:0] trap_address_out,
    output logic [31:0] epc_out
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]  mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] mstatus_rd, mie_rd, mip_rd, irq_pending;
    logic [31:0] operand, wdata;
    logic        writable, do_write, exception, interrupt, is_interrupt;
    logic [3:0]  cause;
    logic        unused_imm;

    assign unused_imm = ^imm_in[31:5];

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mie_rd     = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
    assign mip_rd     = {20'b0, e_irq_in, 3'b0, t_irq_in, 3'b0, s_irq_in, 3'b0};

    always_comb begin
        csr_data_out = 32'h0;
        writable     = 1'b0;
        case (csr_addr_in)
            12'h300: begin csr_data_out = mstatus_rd;         writable = 1'b1; end
            12'h301:       csr_data_out = MISA_VALUE;
            12'h304: begin csr_data_out = mie_rd;             writable = 1'b1; end
            12'h305: begin csr_data_out = mtvec_q;            writable = 1'b1; end
            12'h340: begin csr_data_out = mscratch_q;         writable = 1'b1; end
            12'h341: begin csr_data_out = mepc_q;             writable = 1'b1; end
            12'h342: begin csr_data_out = mcause_q;           writable = 1'b1; end
            12'h343: begin csr_data_out = mtval_q;            writable = 1'b1; end
            12'h344:       csr_data_out = mip_rd;
            12'hB00: begin csr_data_out = mcycle_q[31:0];     writable = 1'b1; end
            12'hB80: begin csr_data_out = mcycle_q[63:32];    writable = 1'b1; end
            12'hB02: begin csr_data_out = minstret_q[31:0];   writable = 1'b1; end
            12'hB82: begin csr_data_out = minstret_q[63:32];  writable = 1'b1; end
            12'hC00:       csr_data_out = mcycle_q[31:0];
            12'hC80:       csr_data_out = mcycle_q[63:32];
            12'hC02:       csr_data_out = minstret_q[31:0];
            12'hC82:       csr_data_out = minstret_q[63:32];
            12'hF14:       csr_data_out = HART_ID;
            default:       csr_data_out = 32'h0;
        endcase
    end

    // Exceptions outrank interrupts; among interrupts external > software > timer.
    assign irq_pending  = mie_rd & mip_rd;
    assign exception    = misaligned_in;
    assign interrupt    = mstatus_mie_q & (|irq_pending);
    assign is_interrupt = interrupt & ~exception;
    assign trap_taken_out = exception | interrupt;

    always_comb begin
        cause = 4'd0;
        if (!exception) begin
            if (irq_pending[11])     cause = 4'd11;
            else if (irq_pending[3]) cause = 4'd3;
            else                     cause = 4'd7;
        end
    end

    assign trap_address_out = {mtvec_q[31:2], 2'b00} +
                              ((is_interrupt && mtvec_q[0]) ? {26'b0, cause, 2'b00} : 32'h0);
    assign epc_out = mepc_q;

    assign operand  = csr_op_in[2] ? {27'b0, imm_in[4:0]} : rs1_in;
    assign do_write = csr_wr_en_in & (csr_op_in[1:0] != 2'b00) & writable & ~trap_taken_out;

    always_comb begin
        case (csr_op_in[1:0])
            2'b01:   wdata = operand;
            2'b10:   wdata = csr_data_out | operand;
            2'b11:   wdata = csr_data_out & ~operand;
            default: wdata = csr_data_out;
        endcase
    end

    // Later assignments win: CSR write, then mret's MIE/MPIE update, then trap entry.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'b0, instret_inc_in & ~trap_taken_out};
        if (do_write) begin
            case (csr_addr_in)
                12'h300: begin mstatus_mie_d = wdata[3]; mstatus_mpie_d = wdata[7]; end
                12'h304: mie_d      = {wdata[11], wdata[7], wdata[3]};
                12'h305: mtvec_d    = {wdata[31:2], 1'b0, wdata[0]};
                12'h340: mscratch_d = wdata;
                12'h341: mepc_d     = {wdata[31:2], 2'b00};
                12'h342: mcause_d   = wdata;
                12'h343: mtval_d    = wdata;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wdata};
                12'hB80: mcycle_d   = {wdata, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wdata};
                12'hB82: minstret_d = {wdata, minstret_q[31:0]};
                default: ;
            endcase
        end
        if (mret_in && !trap_taken_out) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        if (trap_taken_out) begin
            mepc_d         = {pc_in[31:2], 2'b00};
            mcause_d       = {is_interrupt, 27'b0, cause};
            mtval_d        = exception ? iaddr_in : 32'h0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 3'b0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule

// File: doc/rv32_machine_csr_file.md
Name: rv32_machine_csr_file

Overview:
Machine-mode CSR file for the RV32 core. It sits directly downstream of the stage-2 pipeline register and consumes its csr_addr, csr_op, csr_wr_en, rs1, imm and pc fields. It provides CSR read data to the writeback mux and keeps the free-running cycle and retired-instruction counters. It also owns trap entry and mret: it chooses the redirect PC and the trap flag that the fetch stage uses.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (BASE in [31:2], MODE in [1:0]).
MISA_VALUE, 32'h4000_0100, constant returned by misa (RV32I).
HART_ID, 32'h0, constant returned by mhartid.

Ports:
clk_in  input  1  core clock, all state updates on the rising edge
reset_in  input  1  synchronous active-high reset
csr_addr_in  input  12  CSR address
csr_op_in  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; other codes perform no write
csr_wr_en_in  input  1  CSR instruction valid this cycle
rs1_in  input  32  register operand
imm_in  input  32  zimm operand, only bits [4:0] are used
pc_in  input  32  PC of the instruction in this stage
iaddr_in  input  32  faulting target address
misaligned_in  input  1  instruction-address-misaligned exception
mret_in  input  1  mret executing
instret_inc_in  input  1  an instruction retires this cycle
e_irq_in, t_irq_in, s_irq_in  input  1 each  external, timer and software interrupt levels
csr_data_out  output  32  combinational read data at csr_addr_in
trap_taken_out  output  1  redirect to trap_address_out this cycle
trap_address_out  output  32  trap vector target
epc_out  output  32  current mepc, used as the mret target

Behaviour:
- Implemented CSRs and their reset values:
  - mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are stored, other bits read 0. MPP is hardwired 2'b11. Reset value 0x0000_1800.
  - mie 0x304: MSIE[3], MTIE[7], MEIE[11] are stored. Reset 0.
  - mip 0x344: read-only. Bits are live copies of s_irq_in, t_irq_in and e_irq_in at bits 3, 7 and 11.
  - mtvec 0x305: reset MTVEC_RESET. A write of MODE[1] is ignored, so MODE[1] is held at 0.
  - mscratch 0x340, mepc 0x341 (bits [1:0] always 0), mcause 0x342, mtval 0x343: reset 0.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: 64-bit counters, reset 0. Read-only shadows at 0xC00/0xC80/0xC02/0xC82.
  - misa 0x301 = MISA_VALUE, mhartid 0xF14 = HART_ID, mvendorid, marchid and mimpid read 0.
- Unimplemented address: reads return 0, writes are ignored, no exception is raised.
- Reads are combinational with zero latency. csr_data_out always shows the pre-write value, so a CSR instruction gets the old value.
- Write data:
  - Operand is rs1_in for 0xx ops and {27'b0, imm_in[4:0]} for 1xx ops.
  - RW writes the operand, RS writes old|operand, RC writes old&~operand.
  - The write commits on the edge when csr_wr_en_in=1, no trap is taken and the address is writable. Writes to read-only addresses are dropped.
- Counters:
  - mcycle increments by 1 every cycle after reset. minstret increments when instret_inc_in=1 and trap_taken_out=0.
  - Each counter carries from the low word into the high word. Wrap-around from 0xFFFF_FFFF_FFFF_FFFF goes to 0.
  - A CSR write to any half of a counter takes precedence over that cycle's increment for the whole counter. The written half takes the new value and the other half holds.
- Trap detection (combinational):
  - An exception exists when misaligned_in=1.
  - An interrupt exists when mstatus.MIE=1 and (mie & mip) != 0.
  - Priority: exception > external (cause 11) > software (3) > timer (7).
  - trap_taken_out = exception | interrupt.
- Trap address:
  - Exceptions go to {mtvec[31:2],2'b00}.
  - Interrupts go to the same base when MODE=0, or base + 4*cause when MODE=1.
- Trap commit, on the edge where trap_taken_out=1:
  - mepc <= {pc_in[31:2],2'b00}.
  - mcause <= {interrupt,27'b0,cause}.
  - mtval <= iaddr_in for an exception, 0 for an interrupt.
  - MPIE <= MIE, then MIE <= 0.
- mret (when no trap is taken): MIE <= MPIE, MPIE <= 1. epc_out is always the mepc value.
- Simultaneous events:
  - A trap suppresses the CSR write and the mret of the same cycle.
  - A CSR write and mret in the same cycle: mret's MIE/MPIE update wins for those bits.
- Reset asserted at any time, including mid-trap, restores every register to its reset value on that edge. Outputs then follow combinationally: trap_taken_out=0 while the irq inputs are low and misaligned_in=0, epc_out=0, trap_address_out=MTVEC_RESET base.

Test Plan:
- Reset, then read 0x300, 0x301, 0xF14 -> 0x0000_1800, 0x4000_0100, 0x0. After 10 cycles, mcycle reads 10.
- CSRRW 0x340 with rs1=0xDEAD_BEEF -> csr_data_out=0 in that cycle and 0xDEAD_BEEF on the next read. CSRRSI 0x340 with zimm=0x1F -> reads 0xDEAD_BEFF. CSRRCI with zimm=0x0F -> reads 0xDEAD_BEF0.
- mtvec=0x0000_1001, mie=0x800, mstatus=0x8, raise e_irq_in with pc_in=0x200 -> trap_taken_out=1 and trap_address_out=0x102C. Then mepc=0x200, mcause=0x8000_000B, mstatus.MIE=0 and MPIE=1.
- Then pulse mret_in -> MIE=1, MPIE=1, epc_out=0x200.
- misaligned_in with iaddr_in=0x102, csr_wr_en_in=1 to 0x340 and e_irq pending in the same cycle -> mcause=0, mtval=0x102, mscratch unchanged.
- Write mcycle=0xFFFF_FFFF, then idle 2 cycles -> mcycleh=1, mcycle=1. Assert reset mid-count -> all counters read 0 on the next cycle.
